adder_result_checker: RTL and testbench
=======================================

Name: adder_result_checker

Overview:
- Receive-side companion to the 32-bit ripple-carry adder stimulus path.
- Samples each operand set (A, B, cin) when it is issued to the adder under test.
- Computes the golden sum internally and delays it to line up with the DUT result, which arrives LATENCY cycles later.
- Compares golden against DUT (S, cout) and reports per-check status, pass/fail counts, a sticky fail flag, and a capture of the first failing vector for debug.

Parameters:
- WIDTH, 32, operand and sum width.
- LATENCY, 0, cycles from operand issue to valid DUT result; legal range 0..15.
- CNT_W, 16, width of the pass and fail counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous clear of counters, sticky flag, capture registers and pipeline.
- in_valid  input  1  operands valid this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in.
- dut_S  input  WIDTH  DUT sum, valid LATENCY cycles after matching in_valid.
- dut_cout  input  1  DUT carry-out, same timing as dut_S.
- chk_valid  output  1  one-cycle pulse: a comparison completed.
- chk_fail  output  1  qualified by chk_valid: mismatch.
- pass_count  output  CNT_W  saturating count of passing checks.
- fail_count  output  CNT_W  saturating count of failing checks.
- any_fail  output  1  sticky: set on first mismatch.
- cap_A  output  WIDTH  A of first failing vector.
- cap_B  output  WIDTH  B of first failing vector.
- cap_cin  output  1  cin of first failing vector.
- cap_exp  output  WIDTH+1  expected {cout,S} of first failing vector.
- cap_got  output  WIDTH+1  received {dut_cout,dut_S} of first failing vector.

Behaviour:
- Reset (rst=1, asynchronous): every output and all internal state go to 0.
- Golden model: exp = A + B + cin, computed in WIDTH+1 bits, so the MSB is the expected carry-out. Evaluated in the in_valid cycle.
- Alignment pipeline: LATENCY-deep shift register carrying {valid, A, B, cin, exp}.
  - Stage k holds the vector issued k cycles earlier.
  - Back-to-back in_valid on every cycle is fully supported; there is no backpressure and no stall.
- Compare point:
  - For a vector issued at cycle t, compare at cycle t+LATENCY against the dut_S/dut_cout present in that cycle.
  - LATENCY=0: compare is in the issue cycle itself.
- Result timing: chk_valid and chk_fail are registered and assert at cycle t+LATENCY+1 for exactly one cycle per vector.
  - chk_fail=1 iff {dut_cout,dut_S} != exp.
  - chk_fail=0 whenever chk_valid=0.
- Counters (updated in the same edge as chk_valid):
  - pass_count increments on a pass; fail_count increments on a fail.
  - Both saturate at 2^CNT_W-1 and hold; they never wrap.
- Sticky flag and capture:
  - any_fail sets on the first fail and holds until clear or rst.
  - cap_* load only on the fail that sets any_fail. Later fails do not overwrite the capture.
- clear=1 at a clock edge:
  - Same effect as reset, applied synchronously: counters, any_fail, cap_*, chk_valid, chk_fail and all pipeline valids go to 0.
  - Vectors in flight are discarded.
  - A vector presented with in_valid in the clear cycle is also discarded.
- Simultaneous clear and a completing compare: clear wins; that compare produces no pulse and no count.
- Reset mid-operation: all in-flight vectors are lost. The first check after release corresponds to the first in_valid after release.
- in_valid=0 cycles: the DUT inputs are ignored at the corresponding compare cycle.

Test Plan:
- LATENCY=0: A=12, B=4, cin=0, dut_S=16, dut_cout=0 -> next cycle chk_valid=1, chk_fail=0, pass_count=1, any_fail=0.
- Carry boundary: A=32'hFFFFFFFF, B=1, cin=0, dut_S=0, dut_cout=1 -> pass. Then present dut_cout=0 -> fail, fail_count=1, cap_exp=33'h1_00000000, cap_got=33'h0_00000000.
- First-fail capture: fail with A=1, B=0, dut_S=2, then fail with A=5, B=5, dut_S=0 -> fail_count=2, any_fail=1, cap_A=1, cap_B=0, cap_got=2.
- LATENCY=3, back-to-back stream of 8 vectors with the DUT model delayed by 3 cycles -> 8 consecutive chk_valid pulses starting 4 cycles after the first in_valid, pass_count=8. Repeat with vector 5 corrupted -> only pulse 5 has chk_fail=1.
- Saturation: CNT_W=4, 20 passing vectors -> pass_count stops at 15.
- LATENCY=3, assert clear (or rst) 2 cycles after issuing 2 vectors -> no chk_valid pulses follow, all counters 0; the next vector checks normally.

Source files
------------

// File: rtl/adder_result_checker.sv
// adder_result_checker: golden-sum scoreboard for a WIDTH-bit adder, aligned to DUT latency, with counters and first-fail capture
module adder_result_checker #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_S,
  input  logic             dut_cout,
  output logic             chk_valid,
  output logic             chk_fail,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             any_fail,
  output logic [WIDTH-1:0] cap_A,
  output logic [WIDTH-1:0] cap_B,
  output logic             cap_cin,
  output logic [WIDTH:0]   cap_exp,
  output logic [WIDTH:0]   cap_got
);
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH:0]   e;
  } stage_t;
  stage_t           w_in, w_cmp;
  logic [WIDTH:0]   w_exp, w_got;
  logic             w_pass, w_fail;
  assign w_exp = {1'b0, A} + {1'b0, B} + (WIDTH+1)'(cin);
  assign w_in  = '{v: in_valid, a: A, b: B, c: cin, e: w_exp};
  generate
    if (LATENCY == 0) begin : g_comb
      assign w_cmp = w_in;
    end else begin : g_pipe
      stage_t r_pipe [LATENCY];
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          for (int k = 0; k < LATENCY; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= clear ? '0 : w_in;
          for (int k = 1; k < LATENCY; k++) r_pipe[k] <= clear ? '0 : r_pipe[k-1];
        end
      assign w_cmp = r_pipe[LATENCY-1];
    end
  endgenerate
  assign w_got  = {dut_cout, dut_S};
  assign w_fail = w_cmp.v && (w_got != w_cmp.e);
  assign w_pass = w_cmp.v && (w_got == w_cmp.e);
  // counters saturate at all-ones; capture only on the fail that first sets any_fail
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      chk_valid  <= 1'b0;
      chk_fail   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      any_fail   <= 1'b0;
      cap_A      <= '0;
      cap_B      <= '0;
      cap_cin    <= 1'b0;
      cap_exp    <= '0;
      cap_got    <= '0;
    end else if (clear) begin
      chk_valid  <= 1'b0;
      chk_fail   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      any_fail   <= 1'b0;
      cap_A      <= '0;
      cap_B      <= '0;
      cap_cin    <= 1'b0;
      cap_exp    <= '0;
      cap_got    <= '0;
    end else begin
      chk_valid <= w_cmp.v;
      chk_fail  <= w_fail;
      if (w_pass && pass_count != '1) pass_count <= pass_count + CNT_W'(1);
      if (w_fail && fail_count != '1) fail_count <= fail_count + CNT_W'(1);
      if (w_fail && !any_fail) begin
        any_fail <= 1'b1;
        cap_A    <= w_cmp.a;
        cap_B    <= w_cmp.b;
        cap_cin  <= w_cmp.c;
        cap_exp  <= w_cmp.e;
        cap_got  <= w_got;
      end
    end
endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: three checker instances (latency 0, latency 3, 4-bit counters) against a cycle-history model
module tb_adder_result_checker;
  localparam int N = 2048;
  logic        clk = 0, rst = 1, clear = 0, iv = 0, c = 0, go = 0;
  logic [31:0] a = 0, b = 0;
  logic [32:0] d0 = 0, d3 = 0;
  logic        ov [3], of [3], oany [3], occ [3];
  logic [15:0] opc [3], ofc [3];
  logic [31:0] oca [3], ocb [3];
  logic [32:0] oce [3], ocg [3];
  logic [3:0]  p2, f2;
  int          n_chk = 0, n_err = 0;
  int          cyc = 0;
  int          kill [3];
  int          lat [3] = '{0, 3, 0};
  int          mx [3] = '{65535, 65535, 15};
  logic        h_v [N], h_c [N];
  logic [31:0] h_a [N], h_b [N];
  logic        mv [3], mf [3], many [3], mcc [3];
  int          mp [3], mfc [3];
  logic [31:0] mca [3], mcb [3];
  logic [32:0] mce [3], mcg [3];
  logic [31:0] va [8], vb [8];
  logic        vc [8];
  always #5 clk = ~clk;
  assign opc[2] = {12'b0, p2};
  assign ofc[2] = {12'b0, f2};
  adder_result_checker #(.WIDTH(32), .LATENCY(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv), .A(a), .B(b), .cin(c),
    .dut_S(d0[31:0]), .dut_cout(d0[32]), .chk_valid(ov[0]), .chk_fail(of[0]),
    .pass_count(opc[0]), .fail_count(ofc[0]), .any_fail(oany[0]), .cap_A(oca[0]),
    .cap_B(ocb[0]), .cap_cin(occ[0]), .cap_exp(oce[0]), .cap_got(ocg[0]));
  adder_result_checker #(.WIDTH(32), .LATENCY(3), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv), .A(a), .B(b), .cin(c),
    .dut_S(d3[31:0]), .dut_cout(d3[32]), .chk_valid(ov[1]), .chk_fail(of[1]),
    .pass_count(opc[1]), .fail_count(ofc[1]), .any_fail(oany[1]), .cap_A(oca[1]),
    .cap_B(ocb[1]), .cap_cin(occ[1]), .cap_exp(oce[1]), .cap_got(ocg[1]));
  adder_result_checker #(.WIDTH(32), .LATENCY(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv), .A(a), .B(b), .cin(c),
    .dut_S(d0[31:0]), .dut_cout(d0[32]), .chk_valid(ov[2]), .chk_fail(of[2]),
    .pass_count(p2), .fail_count(f2), .any_fail(oany[2]), .cap_A(oca[2]),
    .cap_B(ocb[2]), .cap_cin(occ[2]), .cap_exp(oce[2]), .cap_got(ocg[2]));
  function automatic logic [32:0] sum(input logic [31:0] x, input logic [31:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + 33'(ci);
  endfunction
  task automatic chk(input string nm, input int i, input logic [63:0] g, input logic [63:0] e);
    n_chk++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s inst%0d got=%h expected=%h t=%0t", nm, i, g, e, $time);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] aa, input logic [31:0] bb, input logic cc,
                      input logic [32:0] dd0, input logic [32:0] dd3, input logic cl, input logic rr);
    @(posedge clk);
    #1;
    iv = v; a = aa; b = bb; c = cc; d0 = dd0; d3 = dd3; clear = cl; rst = rr;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // model: a vector issued at cycle s completes at s+lat unless a clear/reset hit any cycle in s..s+lat
  initial begin
    for (int i = 0; i < 3; i++) begin
      kill[i] = -1; mv[i] = 0; mf[i] = 0; many[i] = 0; mcc[i] = 0;
      mp[i] = 0; mfc[i] = 0; mca[i] = 0; mcb[i] = 0; mce[i] = 0; mcg[i] = 0;
    end
    forever begin
      @(posedge clk);
      h_v[cyc%N] = iv; h_a[cyc%N] = a; h_b[cyc%N] = b; h_c[cyc%N] = c;
      for (int i = 0; i < 3; i++) begin
        int s;
        logic [32:0] e, g;
        s = cyc - lat[i];
        g = (i == 1) ? d3 : d0;
        if (rst || clear) begin
          kill[i] = cyc; mv[i] = 0; mf[i] = 0; many[i] = 0; mcc[i] = 0;
          mp[i] = 0; mfc[i] = 0; mca[i] = 0; mcb[i] = 0; mce[i] = 0; mcg[i] = 0;
        end else if (s > kill[i] && h_v[s%N]) begin
          e = sum(h_a[s%N], h_b[s%N], h_c[s%N]);
          mv[i] = 1;
          mf[i] = (g != e);
          if (!mf[i] && mp[i] < mx[i]) mp[i]++;
          if (mf[i] && mfc[i] < mx[i]) mfc[i]++;
          if (mf[i] && !many[i]) begin
            many[i] = 1; mca[i] = h_a[s%N]; mcb[i] = h_b[s%N]; mcc[i] = h_c[s%N]; mce[i] = e; mcg[i] = g;
          end
        end else begin
          mv[i] = 0; mf[i] = 0;
        end
      end
      cyc++;
    end
  end
  initial forever begin
    @(negedge clk);
    if (go) for (int i = 0; i < 3; i++) begin
      logic z;
      z = rst;
      chk("chk_valid", i, 64'(ov[i]), z ? 64'(0) : 64'(mv[i]));
      chk("chk_fail", i, 64'(of[i]), z ? 64'(0) : 64'(mf[i]));
      chk("pass_count", i, 64'(opc[i]), z ? 64'(0) : 64'(mp[i]));
      chk("fail_count", i, 64'(ofc[i]), z ? 64'(0) : 64'(mfc[i]));
      chk("any_fail", i, 64'(oany[i]), z ? 64'(0) : 64'(many[i]));
      chk("cap_A", i, 64'(oca[i]), z ? 64'(0) : 64'(mca[i]));
      chk("cap_B", i, 64'(ocb[i]), z ? 64'(0) : 64'(mcb[i]));
      chk("cap_cin", i, 64'(occ[i]), z ? 64'(0) : 64'(mcc[i]));
      chk("cap_exp", i, 64'(oce[i]), z ? 64'(0) : 64'(mce[i]));
      chk("cap_got", i, 64'(ocg[i]), z ? 64'(0) : 64'(mcg[i]));
    end
  end
  initial begin
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'h89AB_CDEF * 32'(k + 1);
      vb[k] = 32'hFFFF_0000 ^ 32'(k * 977);
      vc[k] = k[0];
    end
    repeat (2) @(posedge clk);
    go = 1;
    @(negedge clk);
    chk("reset_pass", 0, 64'(opc[0]), 64'(0));
    chk("reset_valid", 1, 64'(ov[1]), 64'(0));
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // latency 0 basic pass
    step(1, 12, 4, 0, 33'd16, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_valid", 0, 64'(ov[0]), 64'(1));
    chk("lit_fail", 0, 64'(of[0]), 64'(0));
    chk("lit_pass", 0, 64'(opc[0]), 64'(1));
    chk("lit_any", 0, 64'(oany[0]), 64'(0));
    // carry boundary pass then fail
    step(1, 32'hFFFF_FFFF, 1, 0, 33'h1_0000_0000, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_carry_pass", 0, 64'(opc[0]), 64'(2));
    step(1, 32'hFFFF_FFFF, 1, 0, 33'h0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_carry_fail", 0, 64'(of[0]), 64'(1));
    chk("lit_fail_count", 0, 64'(ofc[0]), 64'(1));
    chk("lit_cap_exp", 0, 64'(oce[0]), 64'h1_0000_0000);
    chk("lit_cap_got", 0, 64'(ocg[0]), 64'h0);
    // first-fail capture survives a later fail
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 33'd2, 0, 0, 0);
    step(1, 5, 5, 0, 33'd0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_ff_count", 0, 64'(ofc[0]), 64'(2));
    chk("lit_ff_any", 0, 64'(oany[0]), 64'(1));
    chk("lit_ff_capA", 0, 64'(oca[0]), 64'(1));
    chk("lit_ff_capB", 0, 64'(ocb[0]), 64'(0));
    chk("lit_ff_capgot", 0, 64'(ocg[0]), 64'(2));
    // latency 3 back-to-back stream, clean then with vector 5 corrupted
    for (int r = 0; r < 2; r++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      for (int j = 0; j < 12; j++) begin
        logic [32:0] x3;
        x3 = (j >= 3 && j < 11) ? sum(va[j-3], vb[j-3], vc[j-3]) : 33'h0;
        if (r == 1 && j == 7) x3 = x3 ^ 33'h1;
        if (j < 8) step(1, va[j], vb[j], vc[j], sum(va[j], vb[j], vc[j]), x3, 0, 0);
        else step(0, 0, 0, 0, 0, x3, 0, 0);
      end
      idle(1);
      @(negedge clk);
      chk("lit_stream_pass", 1, 64'(opc[1]), r == 0 ? 64'(8) : 64'(7));
      chk("lit_stream_fail", 1, 64'(ofc[1]), r == 0 ? 64'(0) : 64'(1));
      if (r == 1) chk("lit_stream_capA", 1, 64'(oca[1]), 64'(va[4]));
    end
    // saturation on the 4-bit counter instance
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++) step(1, 32'(k), 32'(3 * k), 1, sum(32'(k), 32'(3 * k), 1), 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_sat4", 2, 64'(opc[2]), 64'(15));
    chk("lit_sat16", 0, 64'(opc[0]), 64'(20));
    // clear two cycles after issuing two vectors on latency 3
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 10, 20, 0, 33'd30, 0, 0, 0);
    step(1, 11, 21, 0, 33'd32, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 33'd30, 1, 0);
    step(0, 0, 0, 0, 0, 33'd32, 0, 0);
    idle(4);
    @(negedge clk);
    chk("lit_clr_pass", 1, 64'(opc[1]), 64'(0));
    chk("lit_clr_fail", 1, 64'(ofc[1]), 64'(0));
    step(1, 7, 8, 1, 33'd16, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 33'd16, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_after_clr", 1, 64'(opc[1]), 64'(1));
    // asynchronous reset mid-flight
    step(1, 2, 3, 0, 33'd5, 0, 0, 0);
    step(1, 4, 5, 0, 33'd9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 33'd5, 0, 0);
    idle(4);
    @(negedge clk);
    chk("lit_rst_pass", 1, 64'(opc[1]), 64'(0));
    chk("lit_rst_fail", 1, 64'(ofc[1]), 64'(0));
    step(1, 100, 200, 1, 33'd301, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 33'd301, 0, 0);
    idle(2);
    @(negedge clk);
    chk("lit_after_rst", 1, 64'(opc[1]), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
